// File: rtl/i2s_pkg.sv
// Shared I2S receive types: FSM states, default widths, channel-select encodings.
package i2s_pkg;

  typedef enum logic [2:0] {
    UNLOCKED = 3'd0,
    SHIFT_L  = 3'd1,
    PAD_L    = 3'd2,
    SHIFT_R  = 3'd3,
    PAD_R    = 3'd4
  } state_t;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_SLOT_WIDTH   = 32;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_slot_deserializer.sv
// MSB-first slot capture shared by both channels; a short slot leaves its LSBs zero.
// Commit is combinational: sample already includes the sd bit of the committing edge.
module i2s_slot_deserializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    shift,
  input  logic                    slot_end,
  input  logic                    sd,
  output logic                    last_bit,
  output logic                    commit,
  output logic [SAMPLE_WIDTH-1:0] sample
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  logic [CW-1:0]           bit_cnt;
  logic [CW-1:0]           pos;
  logic [SAMPLE_WIDTH-1:0] sreg;
  logic [SAMPLE_WIDTH-1:0] placed;

  // Each bit lands at its final position, so the register is zero-filled by construction.
  assign pos      = CW'(SAMPLE_WIDTH - 1) - bit_cnt;
  assign placed   = sreg | ({{(SAMPLE_WIDTH-1){1'b0}}, sd} << pos);
  assign last_bit = (bit_cnt == CW'(SAMPLE_WIDTH - 1));
  assign commit   = shift && (last_bit || slot_end);
  assign sample   = placed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (start) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= placed;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_rx_frame.sv
// I2S receiver: frame lock, L/R capture, pair register with valid/ready; zero added latency.
// A pair completing while the held pair is unconsumed is dropped and flags overrun
// (counted in overrun_count when I2S_RX_OVERRUN_COUNT_EN is defined).
module i2s_rx_frame
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH    = DEFAULT_SLOT_WIDTH,
  parameter int OVR_CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    ws,
  input  logic                    sd,
  output logic [SAMPLE_WIDTH-1:0] pcm_left,
  output logic [SAMPLE_WIDTH-1:0] pcm_right,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    locked,
  output logic                    overrun,
  input  logic                    clear_overrun
`ifdef I2S_RX_OVERRUN_COUNT_EN
  ,
  output logic [OVR_CNT_WIDTH-1:0] overrun_count
`endif
);

  localparam int SCW = $clog2(SLOT_WIDTH + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    ws_q;
  logic                    ws_edge;
  logic                    ws_rise;
  logic                    ws_fall;
  logic [SCW-1:0]          slot_cnt;
  logic                    slot_over;
  logic                    in_left;
  logic                    in_right;
  logic                    lose;
  logic                    shift;
  logic                    start;
  logic                    last_bit;
  logic                    commit;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic                    pair_done;
  logic                    consume;
  logic                    load;
  logic                    drop;

  assign ws_edge   = (ws != ws_q);
  assign ws_rise   = ws_edge && (ws == RIGHT);
  assign ws_fall   = ws_edge && (ws == LEFT);
  assign in_left   = (state == SHIFT_L) || (state == PAD_L);
  assign in_right  = (state == SHIFT_R) || (state == PAD_R);
  assign slot_over = (slot_cnt == SCW'(SLOT_WIDTH)) && !ws_edge;
  assign lose      = (in_left && ws_fall) || (in_right && ws_rise) || ((in_left || in_right) && slot_over);
  assign shift     = enable && !lose && ((state == SHIFT_L) || (state == SHIFT_R));
  assign start     = enable && ((state == UNLOCKED) ? ws_fall : (!lose && ws_edge));
  assign locked    = (state != UNLOCKED);

  i2s_slot_deserializer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .shift    (shift),
    .slot_end (ws_edge),
    .sd       (sd),
    .last_bit (last_bit),
    .commit   (commit),
    .sample   (sample)
  );

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = UNLOCKED;
    end else begin
      case (state)
        UNLOCKED: if (ws_fall) state_nxt = SHIFT_L;
        SHIFT_L, PAD_L: begin
          if (lose)                                state_nxt = UNLOCKED;
          else if (ws_rise)                        state_nxt = SHIFT_R;
          else if ((state == SHIFT_L) && last_bit) state_nxt = PAD_L;
        end
        SHIFT_R, PAD_R: begin
          if (lose)                                state_nxt = UNLOCKED;
          else if (ws_fall)                        state_nxt = SHIFT_L;
          else if ((state == SHIFT_R) && last_bit) state_nxt = PAD_R;
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      ws_q     <= 1'b0;
      slot_cnt <= '0;
    end else begin
      state <= state_nxt;
      ws_q  <= ws;
      if (start)                  slot_cnt <= '0;
      else if (state != UNLOCKED) slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Pair handshake: a completing pair may replace one being consumed on the same edge.
  assign pair_done = commit && (state == SHIFT_R);
  assign consume   = pcm_valid && pcm_ready;
  assign load      = pair_done && (!pcm_valid || consume);
  assign drop      = pair_done && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_hold <= '0;
      pcm_left  <= '0;
      pcm_right <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (commit && (state == SHIFT_L)) left_hold <= sample;
      if (load) begin
        pcm_left  <= left_hold;
        pcm_right <= sample;
        pcm_valid <= 1'b1;
      end else if (consume) begin
        pcm_valid <= 1'b0;
      end
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

`ifdef I2S_RX_OVERRUN_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_count <= '0;
    end else if (drop) begin
      if (overrun_count != {OVR_CNT_WIDTH{1'b1}}) overrun_count <= overrun_count + 1'b1;
    end else if (clear_overrun) begin
      overrun_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_frame.sv
// Randomized and directed I2S frames checked every cycle against a slot-level model.
module tb_i2s_rx_frame;

  localparam int SW   = 16;
  localparam int SLW  = 32;
  localparam int OCW  = 8;
  localparam int MAXN = 4096;
  localparam int K_LEFT = 0, K_RIGHT = 1, K_VALID = 2, K_LOCK = 3, K_OVR = 4, K_CNT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          ws = 1'b0;
  logic          sd = 1'b0;
  logic          pcm_ready = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [SW-1:0] pcm_left;
  logic [SW-1:0] pcm_right;
  logic          pcm_valid;
  logic          locked;
  logic          overrun;
`ifdef I2S_RX_OVERRUN_COUNT_EN
  logic [OCW-1:0] overrun_count;
`endif

  always #5 clk = ~clk;

  i2s_rx_frame #(
    .SAMPLE_WIDTH  (SW),
    .SLOT_WIDTH    (SLW),
    .OVR_CNT_WIDTH (OCW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .ws            (ws),
    .sd            (sd),
    .pcm_left      (pcm_left),
    .pcm_right     (pcm_right),
    .pcm_valid     (pcm_valid),
    .pcm_ready     (pcm_ready),
    .locked        (locked),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
`ifdef I2S_RX_OVERRUN_COUNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  // Per-cycle stimulus tables
  logic ws_arr [MAXN];
  logic sd_arr [MAXN];
  logic en_arr [MAXN];
  logic rdy_arr[MAXN];
  logic clr_arr[MAXN];
  int   np = 0;
  logic cur_ch = 1'b0;
  int   rst_at = -1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } lit_t;
  lit_t lits[$];

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic          m_lock, m_ch, m_done, m_prev, m_valid, m_ovr;
  int            m_start;
  logic [SW-1:0] m_lval, m_l, m_r, m_pr;
  logic          m_pair;
  int            m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv, input int cyc);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  function automatic int push_slot(input int len, input logic [SW-1:0] val);
    int st;
    st = np;
    for (int i = 0; i < len; i++) ws_arr[np + i] = cur_ch;
    for (int k = 0; k < len; k++)
      if (k < SW) sd_arr[np + 1 + k] = 1'(val >> (SW - 1 - k));
    np += len;
    cur_ch = ~cur_ch;
    return st;
  endfunction

  function automatic void idle(input int len, input logic w);
    for (int i = 0; i < len; i++) ws_arr[np + i] = w;
    np += len;
    cur_ch = ~w;
  endfunction

  function automatic void lit(input int c, input int k, input logic [31:0] v);
    lit_t e;
    e.cyc = c; e.kind = k; e.val = v;
    lits.push_back(e);
  endfunction

  function automatic logic [SW-1:0] gather(input int st, input int k);
    logic [SW-1:0] v;
    v = '0;
    for (int j = 0; j < k; j++) v = v | (SW'(sd_arr[st + 1 + j]) << (SW - 1 - j));
    return v;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_ch = 0; m_done = 0; m_prev = 0; m_valid = 0; m_ovr = 0;
    m_start = 0; m_lval = '0; m_l = '0; m_r = '0; m_pr = '0; m_pair = 0; m_cnt = 0;
  endtask

  task automatic commit_slot(input int k);
    logic [SW-1:0] smp;
    smp = gather(m_start, k);
    if (m_ch == 1'b0) m_lval = smp;
    else begin m_pair = 1; m_pr = smp; end
    m_done = 1;
  endtask

  // Slot-level view: a slot is a run of constant ws; its data is sd on the following edges.
  task automatic model_step(input int n);
    logic w, change, consume, drop;
    int   k;
    w = ws_arr[n];
    change = (w != m_prev);
    m_pair = 0;
    drop = 0;
    consume = m_valid && rdy_arr[n];
    if (!en_arr[n]) begin
      m_lock = 0;
    end else if (!m_lock) begin
      if (change && w == 1'b0) begin
        m_lock = 1; m_ch = 0; m_start = n; m_done = 0;
      end
    end else begin
      k = n - m_start;
      if (change) begin
        if (!m_done) commit_slot(k);
        m_ch = w; m_start = n; m_done = 0;
      end else if (k > SLW) begin
        m_lock = 0;
      end else if (!m_done && k == SW) begin
        commit_slot(k);
      end
    end
    if (m_pair) begin
      if (!m_valid || consume) begin
        m_valid = 1; m_l = m_lval; m_r = m_pr;
      end else begin
        drop = 1; m_ovr = 1;
        if (m_cnt < (1 << OCW) - 1) m_cnt++;
      end
    end else if (consume) begin
      m_valid = 0;
    end
    if (!drop && clr_arr[n]) begin m_ovr = 0; m_cnt = 0; end
    m_prev = w;
  endtask

  initial begin
    int sL, sR, s1, s2, s3, s4, c, t1, t2, d1, d2, d3, e1, e2, e3, e4, f1, f2, f3, f4, g0, r, len;

    for (int i = 0; i < MAXN; i++) begin
      ws_arr[i] = 0; sd_arr[i] = 1'($urandom); en_arr[i] = 1; rdy_arr[i] = 1; clr_arr[i] = 0;
    end

    // Lock and capture
    idle(4, 1'b1);
    sL = push_slot(32, 16'hA5C3);
    sR = push_slot(32, 16'h1234);
    lit(sL - 1, K_LOCK, 0); lit(sL, K_LOCK, 1);
    lit(sR + 15, K_VALID, 0);
    lit(sR + 16, K_VALID, 1); lit(sR + 16, K_LEFT, 32'hA5C3); lit(sR + 16, K_RIGHT, 32'h1234);
    lit(sR + 17, K_VALID, 0);

    // Backpressure over two frames, then clear
    s1 = push_slot(32, 16'h1111); s2 = push_slot(32, 16'h2222);
    s3 = push_slot(32, 16'h3333); s4 = push_slot(32, 16'h4444);
    c = s4 + 20;
    for (int i = s1; i <= c; i++) rdy_arr[i] = 0;
    clr_arr[c] = 1;
    lit(s4 + 15, K_OVR, 0);
    lit(s4 + 16, K_OVR, 1); lit(s4 + 16, K_VALID, 1);
    lit(s4 + 16, K_LEFT, 32'h1111); lit(s4 + 16, K_RIGHT, 32'h2222);
    lit(c, K_OVR, 0); lit(c, K_VALID, 1); lit(c + 1, K_VALID, 0);
`ifdef I2S_RX_OVERRUN_COUNT_EN
    lit(c - 1, K_CNT, 1); lit(c, K_CNT, 0);
`endif

    // Truncated 8-bit slots
    t1 = push_slot(8, 16'hAB00); t2 = push_slot(8, 16'hCD00);
    void'(push_slot(32, 16'($urandom))); void'(push_slot(32, 16'($urandom)));
    lit(t2 + 8, K_LEFT, 32'hAB00); lit(t2 + 8, K_RIGHT, 32'hCD00);
    lit(t2 + 8, K_VALID, 1); lit(t2 + 8, K_LOCK, 1); lit(t1 + 4, K_LOCK, 1);

    // Loss of lock: left held for 40 clocks
    d1 = push_slot(40, 16'($urandom));
    d2 = push_slot(32, 16'($urandom));
    d3 = push_slot(32, 16'($urandom));
    void'(push_slot(32, 16'($urandom)));
    lit(d1 + 32, K_LOCK, 1); lit(d1 + 33, K_LOCK, 0);
    lit(d2 + 16, K_VALID, 0); lit(d3 - 1, K_LOCK, 0); lit(d3, K_LOCK, 1);

    // Pair completes on the edge the held pair is consumed
    e1 = push_slot(32, 16'h5A5A); e2 = push_slot(32, 16'hC3C3);
    e3 = push_slot(32, 16'h0F0F); e4 = push_slot(32, 16'hF00D);
    for (int i = e1; i <= e4 + 15; i++) rdy_arr[i] = 0;
    lit(e2 + 16, K_VALID, 1);
    lit(e4 + 15, K_LEFT, 32'h5A5A); lit(e4 + 15, K_RIGHT, 32'hC3C3);
    lit(e4 + 16, K_VALID, 1); lit(e4 + 16, K_OVR, 0);
    lit(e4 + 16, K_LEFT, 32'h0F0F); lit(e4 + 16, K_RIGHT, 32'hF00D);
    lit(e3 + 1, K_VALID, 1);

    // Reset halfway through a left slot
    f1 = push_slot(32, 16'h7E7E); rst_at = f1 + 8;
    f2 = push_slot(32, 16'h0001);
    f3 = push_slot(32, 16'hBEEF); f4 = push_slot(32, 16'h1357);
    lit(f2 + 16, K_VALID, 0); lit(f3 - 1, K_LOCK, 0); lit(f3, K_LOCK, 1);
    lit(f4 + 16, K_VALID, 1); lit(f4 + 16, K_LEFT, 32'hBEEF); lit(f4 + 16, K_RIGHT, 32'h1357);

    // Randomized frames: short, normal and overlong slots
    g0 = np;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      len = $urandom_range(1, 15);
      else if (r < 18) len = $urandom_range(33, 40);
      else             len = $urandom_range(16, 32);
      void'(push_slot(len, 16'($urandom)));
    end
    idle(8, cur_ch);
    for (int i = g0; i < np; i++) begin
      rdy_arr[i] = ($urandom_range(0, 9) < 7);
      clr_arr[i] = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) begin en_arr[i] = 0; en_arr[i + 1] = 0; end
    end

    // Power-on reset
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", 32'(locked), 0, -1);
    check("reset_valid", 32'(pcm_valid), 0, -1);
    check("reset_left", 32'(pcm_left), 0, -1);
    check("reset_right", 32'(pcm_right), 0, -1);
    check("reset_overrun", 32'(overrun), 0, -1);
    rst_n = 1'b1;

    for (int n = 0; n < np; n++) begin
      @(negedge clk);
      ws = ws_arr[n]; sd = sd_arr[n]; enable = en_arr[n];
      pcm_ready = rdy_arr[n]; clear_overrun = clr_arr[n];
      if (n == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("midrst_locked", 32'(locked), 0, n);
        check("midrst_valid", 32'(pcm_valid), 0, n);
        check("midrst_left", 32'(pcm_left), 0, n);
        check("midrst_right", 32'(pcm_right), 0, n);
        check("midrst_overrun", 32'(overrun), 0, n);
        model_reset();
        #1 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      model_step(n);
      check("locked", 32'(locked), 32'(m_lock), n);
      check("pcm_valid", 32'(pcm_valid), 32'(m_valid), n);
      if (m_valid) begin
        check("pcm_left", 32'(pcm_left), 32'(m_l), n);
        check("pcm_right", 32'(pcm_right), 32'(m_r), n);
      end
      check("overrun", 32'(overrun), 32'(m_ovr), n);
`ifdef I2S_RX_OVERRUN_COUNT_EN
      check("overrun_count", 32'(overrun_count), 32'(m_cnt), n);
`endif
      foreach (lits[i]) begin
        if (lits[i].cyc == n) begin
          case (lits[i].kind)
            K_LEFT:  check("lit_left", 32'(pcm_left), lits[i].val, n);
            K_RIGHT: check("lit_right", 32'(pcm_right), lits[i].val, n);
            K_VALID: check("lit_valid", 32'(pcm_valid), lits[i].val, n);
            K_LOCK:  check("lit_locked", 32'(locked), lits[i].val, n);
            K_OVR:   check("lit_overrun", 32'(overrun), lits[i].val, n);
`ifdef I2S_RX_OVERRUN_COUNT_EN
            K_CNT:   check("lit_overrun_count", 32'(overrun_count), lits[i].val, n);
`endif
            default: ;
          endcase
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
